// File: rtl/ps2_move_entry.sv
// PS/2 set-2 keyboard receiver and move-entry front end: deserialises frames, filters
// make/break/extended codes and assembles a letter+digit move confirmed by Enter.
module ps2_move_entry #(
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic       clock27,
    input  logic       resetN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic       moveAck,
    output logic [2:0] letterOut,
    output logic [2:0] numberOut,
    output logic       letterValid,
    output logic       numberValid,
    output logic       moveValid,
    output logic       frameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HAVE_L, HAVE_LN, PEND} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;

    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          start_bad;
    logic          parity_bad;
    logic [TW-1:0] idle_cnt;
    logic          byte_valid;
    logic [7:0]    rx_byte;

    logic          break_flag;
    logic          ext_flag;
    logic          key_valid;
    logic [7:0]    key_code;

    logic          is_letter;
    logic          is_digit;
    logic          is_enter;
    logic          is_bksp;
    logic          is_esc;
    logic [2:0]    key_idx;

    state_t        state;
    state_t        next_state;
    logic [2:0]    next_letter;
    logic [2:0]    next_number;
    logic          next_lv;
    logic          next_nv;
    logic          next_mv;

    // Synchronisers idle high so release from reset never looks like a clock fall
    always_ff @(posedge clock27 or negedge resetN) begin
        if (!resetN) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2Clk};
            data_sync <= {data_sync[0], ps2Data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = ~clk_sync[1] & clk_prev;
    assign bit_in = data_sync[1];

    // Start/parity faults are remembered and reported together at the stop bit
    always_ff @(posedge clock27 or negedge resetN) begin
        if (!resetN) begin
            bit_cnt    <= '0;
            shift      <= '0;
            start_bad  <= 1'b0;
            parity_bad <= 1'b0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frameError <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frameError <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    start_bad <= bit_in;
                    bit_cnt   <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {bit_in, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    parity_bad <= ~(^shift ^ bit_in);
                    bit_cnt    <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if (start_bad || parity_bad || !bit_in) begin
                        frameError <= 1'b1;
                    end else begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shift;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt  <= 4'd0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // Break swallows the following byte; extended passes only keypad Enter
    always_ff @(posedge clock27 or negedge resetN) begin
        if (!resetN) begin
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= '0;
        end else begin
            key_valid <= 1'b0;
            if (byte_valid) begin
                if (break_flag) begin
                    break_flag <= 1'b0;
                    ext_flag   <= 1'b0;
                end else if (rx_byte == 8'hF0) begin
                    break_flag <= 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (ext_flag) begin
                    ext_flag <= 1'b0;
                    if (rx_byte == 8'h5A) begin
                        key_valid <= 1'b1;
                        key_code  <= rx_byte;
                    end
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= rx_byte;
                end
            end
        end
    end

    always_comb begin
        is_letter = 1'b0;
        is_digit  = 1'b0;
        is_enter  = 1'b0;
        is_bksp   = 1'b0;
        is_esc    = 1'b0;
        key_idx   = 3'd0;
        case (key_code)
            8'h1C: begin is_letter = 1'b1; key_idx = 3'd0; end
            8'h32: begin is_letter = 1'b1; key_idx = 3'd1; end
            8'h21: begin is_letter = 1'b1; key_idx = 3'd2; end
            8'h23: begin is_letter = 1'b1; key_idx = 3'd3; end
            8'h24: begin is_letter = 1'b1; key_idx = 3'd4; end
            8'h2B: begin is_letter = 1'b1; key_idx = 3'd5; end
            8'h34: begin is_letter = 1'b1; key_idx = 3'd6; end
            8'h33: begin is_letter = 1'b1; key_idx = 3'd7; end
            8'h16: begin is_digit  = 1'b1; key_idx = 3'd0; end
            8'h1E: begin is_digit  = 1'b1; key_idx = 3'd1; end
            8'h26: begin is_digit  = 1'b1; key_idx = 3'd2; end
            8'h25: begin is_digit  = 1'b1; key_idx = 3'd3; end
            8'h2E: begin is_digit  = 1'b1; key_idx = 3'd4; end
            8'h36: begin is_digit  = 1'b1; key_idx = 3'd5; end
            8'h3D: begin is_digit  = 1'b1; key_idx = 3'd6; end
            8'h3E: begin is_digit  = 1'b1; key_idx = 3'd7; end
            8'h5A: is_enter = 1'b1;
            8'h66: is_bksp  = 1'b1;
            8'h76: is_esc   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock27 or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            letterOut   <= '0;
            numberOut   <= '0;
            letterValid <= 1'b0;
            numberValid <= 1'b0;
            moveValid   <= 1'b0;
        end else begin
            state       <= next_state;
            letterOut   <= next_letter;
            numberOut   <= next_number;
            letterValid <= next_lv;
            numberValid <= next_nv;
            moveValid   <= next_mv;
        end
    end

    // Digits and letters keep their last value when their valid flag drops
    always_comb begin
        next_state  = state;
        next_letter = letterOut;
        next_number = numberOut;
        next_lv     = letterValid;
        next_nv     = numberValid;
        next_mv     = moveValid;
        case (state)
            IDLE: begin
                if (key_valid && is_letter) begin
                    next_letter = key_idx;
                    next_lv     = 1'b1;
                    next_state  = HAVE_L;
                end
            end
            HAVE_L: begin
                if (key_valid) begin
                    if (is_letter) begin
                        next_letter = key_idx;
                    end else if (is_digit) begin
                        next_number = key_idx;
                        next_nv     = 1'b1;
                        next_state  = HAVE_LN;
                    end else if (is_bksp || is_esc) begin
                        next_lv    = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            HAVE_LN: begin
                if (key_valid) begin
                    if (is_enter) begin
                        next_mv    = 1'b1;
                        next_state = PEND;
                    end else if (is_bksp) begin
                        next_nv    = 1'b0;
                        next_state = HAVE_L;
                    end else if (is_esc) begin
                        next_lv    = 1'b0;
                        next_nv    = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            PEND: begin
                if (moveAck) begin
                    next_mv    = 1'b0;
                    next_lv    = 1'b0;
                    next_nv    = 1'b0;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
